// File: rtl/seg7_pkg.sv
// Shared glyph table, FSM state type and constant helpers for the 7-segment display driver.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  // Active-low a..g pattern for one nibble (bit6 = a, bit0 = g).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial binary-to-BCD converter: one shift-add-3 step per clock, DATA_W steps per conversion.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin_in,
  output logic                    busy,
  output logic                    done_c,
  output logic [4*NUM_DIGITS-1:0] bcd_out
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BCD_W-1:0]  bcd_adj;
  logic [BCD_W-1:0]  bcd_nx;
  logic [DATA_W-1:0] shift_nx;

  // Add 3 to every nibble >= 5, then shift the combined BCD:binary word left by one.
  always_comb begin
    bcd_adj = bcd_out;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (bcd_out[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_out[4*k +: 4] + 4'd3;
    end
    {bcd_nx, shift_nx} = {bcd_adj, shift_q} << 1;
  end

  assign done_c = busy && (cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      bcd_out <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
    end else if (start) begin
      shift_q <= bin_in;
      bcd_out <= '0;
      cnt_q   <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      shift_q <= shift_nx;
      bcd_out <= bcd_nx;
      if (done_c) busy <= 1'b0;
      else        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hex_display_driver.sv
// Registered NUM_DIGITS x 7-segment driver: hex or decimal display with
// leading-zero blanking, overflow dashes and free-running blink.
module hex_display_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 3,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_W-1:0]       DATA_IN,
  input  logic                    LOAD,
  input  logic                    MODE,
  input  logic                    BLANK_LZ,
  input  logic                    BLINK_EN,
  output logic                    BUSY,
  output logic                    OVERFLOW,
  output logic [7*NUM_DIGITS-1:0] HEX
);

  localparam int unsigned BCD_W   = 4 * NUM_DIGITS;
  localparam int unsigned BLINK_W = $clog2(BLINK_DIV);
  localparam logic [63:0] DEC_LIMIT = pow10(NUM_DIGITS);

  if (DATA_W > 4 * NUM_DIGITS) begin : g_bad_width
    $error("hex_display_driver: DATA_W must not exceed 4*NUM_DIGITS");
  end

  state_t             state;
  logic [BCD_W-1:0]   digits_q;
  logic               lz_q;
  logic               ovf_pend_q;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic               bcd_busy;
  logic               bcd_done_c;
  logic [BCD_W-1:0]   bcd_out;
  logic               start_c;
  logic               ovf_c;
  logic [7*NUM_DIGITS-1:0] hex_c;

  assign start_c = (state == IDLE) && LOAD && MODE && !bcd_busy;
  assign ovf_c   = 64'(DATA_IN) >= DEC_LIMIT;

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk     (CLK),
    .rst     (RST),
    .start   (start_c),
    .bin_in  (DATA_IN),
    .busy    (bcd_busy),
    .done_c  (bcd_done_c),
    .bcd_out (bcd_out)
  );

  // Capture / convert / commit sequencing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      BUSY       <= 1'b0;
      OVERFLOW   <= 1'b0;
      digits_q   <= '0;
      lz_q       <= 1'b0;
      ovf_pend_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (LOAD) begin
            lz_q <= BLANK_LZ;
            if (MODE) begin
              ovf_pend_q <= ovf_c;
              state      <= CONVERT;
              BUSY       <= 1'b1;
            end else begin
              digits_q <= BCD_W'(DATA_IN);
              OVERFLOW <= 1'b0;
            end
          end
        end
        CONVERT: begin
          if (bcd_done_c) state <= COMMIT;
        end
        COMMIT: begin
          digits_q <= bcd_out;
          OVERFLOW <= ovf_pend_q;
          state    <= IDLE;
          BUSY     <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  // Blink half-period counter; held at zero while blink is disabled.
  always_ff @(posedge CLK) begin
    if (RST || !BLINK_EN) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // Glyph selection, scanning from the most significant digit for zero blanking.
  always_comb begin
    logic [3:0] nib;
    logic [6:0] seg;
    logic       nz_above;
    hex_c    = '0;
    nib      = '0;
    seg      = SEG_BLANK;
    nz_above = 1'b0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      nib = digits_q[4*k +: 4];
      if (OVERFLOW)                                   seg = SEG_DASH;
      else if (lz_q && !nz_above && nib == 4'd0 && k != 0) seg = SEG_BLANK;
      else                                            seg = hex_to_seg(nib);
      if (nib != 4'd0) nz_above = 1'b1;
      if (BLINK_EN && blink_phase) seg = SEG_BLANK;
      hex_c[7*k +: 7] = seg;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) HEX <= {NUM_DIGITS{hex_to_seg(4'd0)}};
    else     HEX <= hex_c;
  end

endmodule
